// File: rtl/lowpass_iir_multichannel.sv
// Time-multiplexed first-order IIR low-pass for several ADC channels, with an optional second
// cascaded stage. One (channel, stage) accumulator is updated per qzt_clk cycle after each sample strobe.
module lowpass_iir_multichannel #(
   parameter int WIDTH  = 20,
   parameter int NCH    = 4,
   parameter int KW     = 4,
   parameter int FRAC   = 8,
   parameter int STAGES = 1
) (
   input  logic                   qzt_clk,
   input  logic                   reset,
   input  logic                   clk_in,
   input  logic [KW-1:0]          k,
   input  logic                   bypass,
   input  logic                   overrun_clr,
   input  logic [NCH*WIDTH-1:0]   Vin,
   output logic [NCH*WIDTH-1:0]   Vout,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   overrun
);

   localparam int AW = WIDTH + FRAC;
   localparam int DW = AW + 1;
   localparam int NS = NCH * STAGES;
   localparam int CW = $clog2(NCH);
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SCAN   = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;

   logic [1:0]              state;
   logic                    clk_in_old;
   logic                    strobe_edge;
   logic [IW-1:0]           idx;
   logic [IW-1:0]           prev_idx;
   logic [CW-1:0]           ch_sel;
   logic                    stage0;
   logic [KW-1:0]           k_lat;
   logic                    bypass_lat;
   logic signed [WIDTH-1:0] vin_lat [NCH];
   logic signed [AW-1:0]    acc [NS];
   logic signed [AW-1:0]    x_in;
   logic signed [AW-1:0]    acc_cur;
   logic signed [AW-1:0]    acc_next;
   logic signed [DW-1:0]    diff;
   logic signed [DW-1:0]    step;

   assign strobe_edge = clk_in & ~clk_in_old;

   // Accumulators are flattened as idx = ch*STAGES + stage, so a stage-1 input sits at idx-1.
   always_comb begin
      ch_sel   = idx[IW-1 -: CW];
      stage0   = (STAGES == 1) ? 1'b1 : ~idx[0];
      prev_idx = idx - 1'b1;
      acc_cur  = acc[idx];
      x_in     = stage0 ? {vin_lat[ch_sel], {FRAC{1'b0}}} : acc[prev_idx];
      diff     = {x_in[AW-1], x_in} - {acc_cur[AW-1], acc_cur};
      step     = diff >>> k_lat;
      acc_next = bypass_lat ? x_in : acc_cur + step[AW-1:0];
   end

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clk_in_old <= 1'b1;
         idx        <= '0;
         k_lat      <= '0;
         bypass_lat <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         Vout       <= '0;
         for (int c = 0; c < NCH; c++) vin_lat[c] <= '0;
         for (int i = 0; i < NS; i++) acc[i] <= '0;
      end else begin
         clk_in_old <= clk_in;
         out_valid  <= 1'b0;
         if (strobe_edge && state != IDLE) overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (strobe_edge) begin
                  for (int c = 0; c < NCH; c++) vin_lat[c] <= Vin[c*WIDTH +: WIDTH];
                  k_lat      <= k;
                  bypass_lat <= bypass;
                  idx        <= '0;
                  state      <= SCAN;
                  busy       <= 1'b1;
               end
            end
            SCAN: begin
               acc[idx] <= acc_next;
               if (idx == LAST_IDX) begin
                  // The last step is always the final stage of the last channel, so take its fresh value.
                  for (int c = 0; c < NCH - 1; c++)
                     Vout[c*WIDTH +: WIDTH] <= acc[c*STAGES + STAGES - 1][AW-1:FRAC];
                  Vout[(NCH-1)*WIDTH +: WIDTH] <= acc_next[AW-1:FRAC];
                  out_valid <= 1'b1;
                  state     <= UPDATE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            UPDATE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
